// File: rtl/nv_nvdla_cdp_wdma_intr_drain.sv
// CDP WDMA interrupt drain: pops layer-done ids once their write ack is back and pulses the done vector.
// Optional perf counters are enabled by defining NV_CDP_WDMA_INTR_PERF_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a matched (ack_cnt != 0, FIFO valid) entry to pop
// PULSE | driving the one-cycle done pulse for the popped layer id
module nv_nvdla_cdp_wdma_intr_drain #(
    parameter int CNT_W = 4
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        intr_fifo_rd_pvld,
    input  logic        intr_fifo_rd_pd,
    output logic        intr_fifo_rd_prdy,
    input  logic        dma_wr_ack_req,
    input  logic        dma_wr_rsp_complete,
    output logic [1:0]  cdp2glb_done_intr_pd,
    output logic        intr_busy,
`ifdef NV_CDP_WDMA_INTR_PERF_EN
    output logic [15:0] perf_done0_cnt,
    output logic [15:0] perf_done1_cnt,
    output logic [31:0] perf_ack_wait_cnt,
`endif
    output logic        intr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             id_q;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] ack_cnt;
    logic             busy_q;
    logic             pop;
    logic             out_underflow;
    logic             out_overflow;
    logic             ack_inc;
    logic             ack_overflow;

    always_comb begin
        state_nxt            = state;
        intr_fifo_rd_prdy    = 1'b0;
        cdp2glb_done_intr_pd = 2'b00;
        case (state)
            IDLE: begin
                intr_fifo_rd_prdy = (ack_cnt != CNT_ZERO);
                if (intr_fifo_rd_prdy && intr_fifo_rd_pvld) begin
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                cdp2glb_done_intr_pd = id_q ? 2'b10 : 2'b01;
                state_nxt            = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop           = intr_fifo_rd_prdy && intr_fifo_rd_pvld;
    assign out_underflow = dma_wr_rsp_complete && !dma_wr_ack_req && (out_cnt == CNT_ZERO);
    assign out_overflow  = dma_wr_ack_req && !dma_wr_rsp_complete && (out_cnt == CNT_MAX);
    // An underflowing complete has no matching request, so it must not release a FIFO entry.
    assign ack_inc       = dma_wr_rsp_complete && !out_underflow;
    assign ack_overflow  = ack_inc && !pop && (ack_cnt == CNT_MAX);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= IDLE;
            id_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                id_q <= intr_fifo_rd_pd;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_cnt <= CNT_ZERO;
        end else if (dma_wr_ack_req && !dma_wr_rsp_complete && !out_overflow) begin
            out_cnt <= out_cnt + CNT_ONE;
        end else if (dma_wr_rsp_complete && !dma_wr_ack_req && !out_underflow) begin
            out_cnt <= out_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ack_cnt <= CNT_ZERO;
        end else if (ack_inc && !pop && !ack_overflow) begin
            ack_cnt <= ack_cnt + CNT_ONE;
        end else if (pop && !ack_inc) begin
            ack_cnt <= ack_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            intr_err <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (out_underflow || out_overflow || ack_overflow) begin
                intr_err <= 1'b1;
            end
            busy_q <= (out_cnt != CNT_ZERO) || (ack_cnt != CNT_ZERO) ||
                      intr_fifo_rd_pvld || (state == PULSE);
        end
    end

    assign intr_busy = busy_q;

`ifdef NV_CDP_WDMA_INTR_PERF_EN
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_done0_cnt    <= 16'd0;
            perf_done1_cnt    <= 16'd0;
            perf_ack_wait_cnt <= 32'd0;
        end else begin
            if (cdp2glb_done_intr_pd[0]) begin
                perf_done0_cnt <= perf_done0_cnt + 16'd1;
            end
            if (cdp2glb_done_intr_pd[1]) begin
                perf_done1_cnt <= perf_done1_cnt + 16'd1;
            end
            if (intr_fifo_rd_pvld && (ack_cnt == CNT_ZERO) && (perf_ack_wait_cnt != 32'hFFFF_FFFF)) begin
                perf_ack_wait_cnt <= perf_ack_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
